// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: handshaked imem fetch, hazard freeze, branch flush.
// Optional build macro FETCH_PERF_EN adds saturating fetch/bubble performance counters.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        flush_idex,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] PC_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_addr;
  logic [31:0] hold_word;

  logic        load_en;
  logic [31:0] load_word;
  logic        fetch_inc;
  logic        bubble_inc;

  assign imem_req   = !rst && (state != HOLD);
  assign imem_addr  = pc;
  assign flush_idex = branch_taken;

  // A word is available for IF/ID either straight from memory or from the freeze buffer.
  assign load_en    = ((state == FETCH) && imem_ready) || (state == HOLD);
  assign load_word  = (state == HOLD) ? hold_word : imem_rdata;
  assign fetch_inc  = !branch_taken && !freeze && load_en;
  assign bubble_inc = branch_taken || (!freeze && !load_en);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= PC_RESET;
      pend_addr <= '0;
      hold_word <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            if (imem_ready) begin
              pc <= branch_address;
            end else begin
              pend_addr <= branch_address;
              state     <= DRAIN;
            end
          end else if (imem_ready) begin
            if (freeze) begin
              hold_word <= imem_rdata;
              state     <= HOLD;
            end else begin
              pc <= pc + PC_INC;
            end
          end
        end
        DRAIN: begin
          // Stale data is discarded; a branch arriving on the completing cycle still wins.
          if (imem_ready) begin
            pc    <= branch_taken ? branch_address : pend_addr;
            state <= FETCH;
          end else if (branch_taken) begin
            pend_addr <= branch_address;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc    <= branch_address;
            state <= FETCH;
          end else if (!freeze) begin
            pc    <= pc + PC_INC;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // IF/ID register: flush beats freeze, freeze beats load, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid    <= 1'b0;
      instruction <= '0;
      PC_out      <= '0;
    end else if (branch_taken) begin
      if_valid    <= 1'b0;
      instruction <= '0;
    end else if (freeze) begin
      if_valid    <= if_valid;
    end else if (load_en) begin
      if_valid    <= 1'b1;
      instruction <= load_word;
      PC_out      <= pc + PC_INC;
    end else begin
      if_valid    <= 1'b0;
      instruction <= '0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (fetch_inc && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bubble_inc && (perf_bubble_cnt != 32'hFFFF_FFFF))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  // Counter enables are left unconsumed when performance counting is not built in.
  logic unused_perf;
  assign unused_perf = fetch_inc ^ bubble_inc;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios then random freeze/branch/ready traffic
// checked against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        flush_idex;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] PC_out;

  logic        w_req, w_flush, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc_out;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
  logic [31:0] w_pf, w_pb;
`endif

  always #5 clk = ~clk;

  // Memory returns a word derived from its address; garbage when not completing.
  assign imem_rdata = imem_ready ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
  assign w_rdata    = imem_ready ? (w_addr ^ KEY) : 32'hDEAD_BEEF;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .flush_idex(flush_idex),
    .if_valid(if_valid), .instruction(instruction), .PC_out(PC_out)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  if_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(w_rdata), .flush_idex(w_flush),
    .if_valid(w_valid), .instruction(w_instr), .PC_out(w_pc_out)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(w_pf), .perf_bubble_cnt(w_pb)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: next fetch address, an optional pending redirect target,
  // an optional word captured under freeze, and the IF/ID contents it implies.
  logic [31:0] m_pc = '0;
  bit          m_redirect = 0;
  logic [31:0] m_target = '0;
  bit          m_held = 0;
  logic [31:0] m_word = '0;
  logic        m_valid = 0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pcout = '0;
  logic [31:0] m_fcnt = '0;
  logic [31:0] m_bcnt = '0;

  task automatic step(input bit r, input bit fz, input bit br, input logic [31:0] ba, input bit rdy);
    bit          exp_req;
    bit          done;
    bit          load;
    logic [31:0] word;
    logic [31:0] ld_word;
    exp_t        e;
    @(negedge clk);
    rst = r; freeze = fz; branch_taken = br; branch_address = ba; imem_ready = rdy;
    #1;
    exp_req = !r && !m_held;
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("flush_idex", {31'd0, flush_idex}, {31'd0, br});

    word    = m_pc ^ KEY;
    done    = rdy && !m_held;
    load    = 0;
    ld_word = '0;
    if (r) begin
      m_pc = '0; m_redirect = 0; m_held = 0;
      m_valid = 0; m_instr = '0; m_pcout = '0; m_fcnt = '0; m_bcnt = '0;
    end else begin
      if (br) begin
        if (m_held) begin
          m_held = 0; m_pc = ba;
        end else if (done) begin
          m_pc = ba; m_redirect = 0;
        end else begin
          m_redirect = 1; m_target = ba;
        end
      end else if (m_held) begin
        if (!fz) begin load = 1; ld_word = m_word; m_held = 0; end
      end else if (done) begin
        if (m_redirect) begin
          m_pc = m_target; m_redirect = 0;
        end else if (fz) begin
          m_held = 1; m_word = word;
        end else begin
          load = 1; ld_word = word;
        end
      end

      if (br) begin
        m_valid = 0; m_instr = '0;
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
      end else if (!fz) begin
        if (load) begin
          m_valid = 1; m_instr = ld_word; m_pcout = m_pc + 32'd4; m_pc = m_pc + 32'd4;
          if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
        end else begin
          m_valid = 0; m_instr = '0;
          if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        end
      end
    end
    e.valid = m_valid; e.instr = m_instr; e.pc_out = m_pcout; e.fcnt = m_fcnt; e.bcnt = m_bcnt;
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge, compare IF/ID against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
        check("instruction", instruction, e.instr);
        check("PC_out", PC_out, e.pc_out);
`ifdef FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, e.fcnt);
        check("perf_bubble_cnt", perf_bubble_cnt, e.bcnt);
`endif
      end
    end
  end

  initial begin
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 1);
    // Zero-wait streaming; wrap instance starts at FFFF_FFFC and wraps to 0.
    step(0, 0, 0, '0, 1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, '0, 1);
    check("wrap_addr1", w_addr, 32'h0);
    check("wrap_pc_out", w_pc_out, 32'h0);
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    // Slow memory at pc=8.
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    // Branch while 0x10 is pending -> drain.
    step(0, 0, 1, 32'h40, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    // Redirect to 0x20 with ready, then freeze the 0x20 completion for 3 cycles.
    step(0, 0, 1, 32'h20, 1);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    // Freeze into HOLD, then branch+freeze together.
    step(0, 1, 0, '0, 1);
    step(0, 1, 1, 32'h100, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    // Reset mid-run clears everything, including counters.
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    for (int i = 0; i < 1500; i++) begin
      bit r, fz, br, rdy;
      logic [31:0] ba;
      r   = ($urandom_range(0, 199) == 0);
      fz  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      ba  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 49) == 0) ba = 32'hFFFF_FFFC;
      step(r, fz, br, ba, rdy);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
